// File: rtl/m_wbinitiator_if.sv
// Command/response port plus Wishbone classic initiator bus for m_wbinitiator.
// The master modport is the initiator's view; slave is the driver/responder side.
interface m_wbinitiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;

    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        ACK_I;
    logic [31:0] DAT_I;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, ACK_I, DAT_I,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_dat, cmd_sel, ACK_I, DAT_I,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O
    );
endinterface

// File: rtl/m_wbinitiator.sv
// Wishbone classic initiator: one bus cycle per accepted command, returning
// read data or a timeout error as a single-cycle response pulse.
module m_wbinitiator #(
    parameter int TIMEOUT_W = 4
) (
    input  logic           CLK_I,
    input  logic           RST_I,
    m_wbinitiator_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RSP
    } state_e;

    state_e                state_q, state_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [31:0]           adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;
    logic [3:0]            sel_q, sel_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                // cmd_ready is implied here: this branch only matters out of reset
                if (bus.cmd_valid) begin
                    adr_d   = bus.cmd_adr;
                    dat_d   = bus.cmd_dat;
                    sel_d   = bus.cmd_sel;
                    we_d    = bus.cmd_we;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // ACK is tested first so it beats a coincident terminal count
                if (bus.ACK_I) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = we_q ? 32'h0 : bus.DAT_I;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else if (&cnt_q) begin
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_dat_d   = 32'h0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'h0;
            dat_q       <= 32'h0;
            sel_q       <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // CYC and STB share one flop: single cycles only, never a held CYC
    assign bus.CYC_O     = cyc_q;
    assign bus.STB_O     = cyc_q;
    assign bus.WE_O      = we_q;
    assign bus.ADR_O     = adr_q;
    assign bus.DAT_O     = dat_q;
    assign bus.SEL_O     = sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.cmd_ready = (state_q == S_IDLE) & RST_I;

endmodule

// File: doc/m_wbinitiator.md
# m_wbinitiator

Command-driven Wishbone classic initiator that turns single read/write requests from a simple valid/ready command port into one Wishbone cycle each, and returns data or a bus-timeout error on a response port. It sits beside m_midgetv_core in the simulation top-levels as a second bus initiator. Test harnesses and loaders use it to drive Wishbone responders such as m_whishbonereg directly, without running core code.

## Interface
- TIMEOUT_W, 4: timeout counter width. An unanswered cycle is aborted after 2^TIMEOUT_W cycles with STB_O high.
- CLK_I  in  1  sole clock; all state changes on rising edge.
- RST_I  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte lane selects.
- rsp_valid  out  1  one-cycle pulse: transaction finished.
- rsp_dat  out  32  read data; 0 on writes and on errors.
- rsp_err  out  1  qualified by rsp_valid; 1 = timeout abort.
- CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe, write enable.
- ADR_O  out  32  Wishbone address.
- DAT_O  out  32  Wishbone write data.
- SEL_O  out  4  Wishbone byte selects.
- ACK_I  in  1  Wishbone acknowledge.
- DAT_I  in  32  Wishbone read data.

## Operation
- States: IDLE, BUS, RSP. All Wishbone outputs and all rsp_* outputs are registered. cmd_ready = (state == IDLE) & RST_I.
- Reset (RST_I low at an edge): state = IDLE. CYC_O = STB_O = WE_O = 0. ADR_O, DAT_O, SEL_O = 0. rsp_valid = rsp_err = 0, rsp_dat = 0. Timeout counter = 0.
- IDLE: on cmd_valid & cmd_ready:
  - latch cmd_adr, cmd_dat, cmd_sel, cmd_we into ADR_O, DAT_O, SEL_O, WE_O;
  - set CYC_O = STB_O = 1; clear counter; go to BUS.
  - ACK_I in IDLE is ignored.
- BUS: CYC_O, STB_O and the address/data/sel/we outputs are held stable.
  - ACK_I = 1: drop CYC_O, STB_O, WE_O. rsp_dat = DAT_I for reads, 0 for writes. rsp_err = 0, rsp_valid = 1. Go to RSP.
  - ACK_I = 0 and counter == 2^TIMEOUT_W-1: drop CYC_O, STB_O, WE_O. rsp_dat = 0, rsp_err = 1, rsp_valid = 1. Go to RSP.
  - Otherwise counter increments.
  - ACK_I and terminal count in the same cycle: ACK wins (no error).
- RSP: rsp_valid is high for exactly this one cycle. Next edge: rsp_valid = 0, go to IDLE.
  - rsp_dat and rsp_err hold their values until the next response.
  - ADR_O, DAT_O and SEL_O keep their last values (don't-care while CYC_O = 0).
- Reset mid-transaction: CYC_O and STB_O are 0 after the reset edge. No rsp_valid is produced for the aborted command.
- Exactly one outstanding transaction at a time; no pipelining, no bursts. CYC_O == STB_O at all times.

## Timing
- Command accepted at edge t: CYC_O and STB_O are high from cycle t+1.
- Zero-wait responder (ACK_I combinational in cycle t+1): STB_O falls at edge t+2, rsp_valid is high in cycle t+2, cmd_ready is high again in cycle t+3.
- Registered responder (ACK_I in cycle t+2): everything shifts by one cycle.
- Minimum issue interval: 3 cycles per transaction.
- Timeout: STB_O is high for exactly 2^TIMEOUT_W cycles (16 at default), then rsp_valid/rsp_err follow in the next cycle.
- cmd_* inputs are sampled only at the accepting edge; later changes have no effect on the cycle in flight.

## Test plan
- Reset then idle: hold RST_I low for 3 cycles. Every output is 0 while RST_I is low. After release, cmd_ready = 1 and CYC_O = 0 indefinitely.
- Write to m_whishbonereg, address 0x40000004, data 0xDEADBEEF, sel 0xF, zero-wait ACK:
  - STB_O high for 1 cycle, WE_O = 1;
  - rsp_valid 2 cycles after acceptance with rsp_err = 0, rsp_dat = 0;
  - a following read of the same address returns rsp_dat = 0xDEADBEEF.
- Wait-state read: ACK_I delayed 5 cycles, DAT_I = 0x12345678.
  - STB_O high for 6 cycles with ADR_O stable;
  - rsp_dat = 0x12345678, rsp_err = 0.
- Timeout: ACK_I never asserted, TIMEOUT_W = 4.
  - STB_O high for exactly 16 cycles;
  - rsp_valid with rsp_err = 1 and rsp_dat = 0;
  - cmd_ready returns 2 cycles after STB_O falls.
- Boundary: ACK_I first asserted in the 16th STB_O cycle gives rsp_err = 0. A stray ACK_I pulse while in IDLE produces no rsp_valid.
- Reset mid-cycle: RST_I low in the 3rd STB_O cycle.
  - CYC_O and STB_O are 0 the next cycle; rsp_valid never pulses;
  - a new command issued after release completes normally.
